// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI encodings and the line-fetch FSM state type.
//   AXI_BURST_INCR - ARBURST encoding for incrementing bursts
//   AXI_RESP_OKAY  - RRESP encoding for a normal response
//   AXI_SIZE_8B    - ARSIZE encoding for 8-byte beats
//   fetch_state_t  - axi_line_fetch FSM states
package axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [2:0] AXI_SIZE_8B    = 3'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/axi_line_fetch_line_buffer.sv
// line_buffer: slot-addressed register array holding one cache line.
//   clk, arstn - clock, asynchronous active-low reset (clears all slots)
//   i_we       - write enable for slot i_idx
//   i_idx      - slot index
//   i_data     - slot write data
//   o_line     - flat line, slot k at bits [k*SLOT_WIDTH +: SLOT_WIDTH]
module line_buffer #(
  parameter int unsigned SLOT_WIDTH = 64,
  parameter int unsigned SLOTS      = 8,
  parameter int unsigned IDX_W      = $clog2(SLOTS)
) (
  input  logic                        clk,
  input  logic                        arstn,
  input  logic                        i_we,
  input  logic [IDX_W-1:0]            i_idx,
  input  logic [SLOT_WIDTH-1:0]       i_data,
  output logic [SLOTS*SLOT_WIDTH-1:0] o_line
);

  logic [SLOT_WIDTH-1:0] r_slots [SLOTS];

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      for (int unsigned i = 0; i < SLOTS; i++) begin
        r_slots[i] <= '0;
      end
    end else if (i_we) begin
      r_slots[i_idx] <= i_data;
    end
  end

  always_comb begin
    o_line = '0;
    for (int unsigned k = 0; k < SLOTS; k++) begin
      o_line[k*SLOT_WIDTH +: SLOT_WIDTH] = r_slots[k];
    end
  end

endmodule

// File: rtl/axi_line_fetch.sv
// axi_line_fetch: AXI4 read initiator refilling one instruction-cache line.
// Issues a single INCR burst for the aligned line holding i_addr, assembles
// the beats into o_line and pulses o_read_last for one cycle when complete.
//   clk, arstn          - clock, asynchronous active-low reset
//   i_start_read/i_addr - refill request and miss byte address
//   o_line/o_read_last  - assembled line and its one-cycle completion pulse
//   o_busy/o_error      - not-idle flag, sticky error for the last burst
//   o_ar*/i_arready     - AXI read address channel
//   i_r*/o_rready       - AXI read data channel
module axi_line_fetch
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned LINE_WIDTH     = 512,
  parameter int unsigned ID_WIDTH       = 4
) (
  input  logic                      clk,
  input  logic                      arstn,
  input  logic                      i_start_read,
  input  logic [ADDR_WIDTH-1:0]     i_addr,
  output logic [LINE_WIDTH-1:0]     o_line,
  output logic                      o_read_last,
  output logic                      o_busy,
  output logic                      o_error,
  output logic [ID_WIDTH-1:0]       o_arid,
  output logic [ADDR_WIDTH-1:0]     o_araddr,
  output logic [7:0]                o_arlen,
  output logic [2:0]                o_arsize,
  output logic [1:0]                o_arburst,
  output logic                      o_arvalid,
  input  logic                      i_arready,
  input  logic [ID_WIDTH-1:0]       i_rid,
  input  logic [AXI_DATA_WIDTH-1:0] i_rdata,
  input  logic [1:0]                i_rresp,
  input  logic                      i_rlast,
  input  logic                      i_rvalid,
  output logic                      o_rready
);

  localparam int unsigned BEATS      = LINE_WIDTH / AXI_DATA_WIDTH;
  localparam int unsigned IDX_W      = $clog2(BEATS);
  localparam int unsigned LINE_BYTES = LINE_WIDTH / 8;

  fetch_state_t          r_state;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [7:0]            r_arlen;
  logic [2:0]            r_arsize;
  logic [1:0]            r_arburst;
  logic                  r_error;
  logic [IDX_W-1:0]      r_beat_cnt;

  logic                  w_beat_we;
  logic                  w_last_beat;

  assign w_beat_we   = (r_state == DATA) && i_rvalid;
  assign w_last_beat = (r_beat_cnt == IDX_W'(BEATS - 1));

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_state    <= IDLE;
      r_araddr   <= '0;
      r_arlen    <= '0;
      r_arsize   <= '0;
      r_arburst  <= '0;
      r_error    <= 1'b0;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start_read) begin
            // Masking keeps every address bit in use while aligning to the line.
            r_araddr   <= i_addr & ~ADDR_WIDTH'(LINE_BYTES - 1);
            r_arlen    <= 8'(BEATS - 1);
            r_arsize   <= AXI_SIZE_8B;
            r_arburst  <= AXI_BURST_INCR;
            r_error    <= 1'b0;
            r_beat_cnt <= '0;
            r_state    <= ADDR;
          end
        end
        ADDR: begin
          if (i_arready) begin
            r_state <= DATA;
          end
        end
        DATA: begin
          if (i_rvalid) begin
            if ((i_rresp != AXI_RESP_OKAY) || (i_rid != '0) || (i_rlast != w_last_beat)) begin
              r_error <= 1'b1;
            end
            // Completion is decided by the beat count alone so a bad RLAST cannot hang the block.
            if (w_last_beat) begin
              r_beat_cnt <= '0;
              r_state    <= DONE;
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  line_buffer #(
    .SLOT_WIDTH (AXI_DATA_WIDTH),
    .SLOTS      (BEATS),
    .IDX_W      (IDX_W)
  ) u_line_buffer (
    .clk    (clk),
    .arstn  (arstn),
    .i_we   (w_beat_we),
    .i_idx  (r_beat_cnt),
    .i_data (i_rdata),
    .o_line (o_line)
  );

  assign o_arvalid   = (r_state == ADDR);
  assign o_rready    = (r_state == DATA);
  assign o_read_last = (r_state == DONE);
  assign o_busy      = (r_state != IDLE);
  assign o_error     = r_error;
  assign o_arid      = '0;
  assign o_araddr    = r_araddr;
  assign o_arlen     = r_arlen;
  assign o_arsize    = r_arsize;
  assign o_arburst   = r_arburst;

endmodule

// File: tb/tb_axi_line_fetch.sv
// tb_axi_line_fetch: self-checking bench for axi_line_fetch with a
// transaction-level reference model (aligned address, expected line,
// expected sticky error, expected cycle of the completion pulse).
module tb_axi_line_fetch;

  logic         clk;
  logic         arstn;
  logic         i_start_read;
  logic [63:0]  i_addr;
  logic [511:0] o_line;
  logic         o_read_last;
  logic         o_busy;
  logic         o_error;
  logic [3:0]   o_arid;
  logic [63:0]  o_araddr;
  logic [7:0]   o_arlen;
  logic [2:0]   o_arsize;
  logic [1:0]   o_arburst;
  logic         o_arvalid;
  logic         i_arready;
  logic [3:0]   i_rid;
  logic [63:0]  i_rdata;
  logic [1:0]   i_rresp;
  logic         i_rlast;
  logic         i_rvalid;
  logic         o_rready;

  int n_checks = 0;
  int n_fail   = 0;
  int n_last   = 0;
  int n_ar     = 0;

  axi_line_fetch #(
    .ADDR_WIDTH     (64),
    .AXI_DATA_WIDTH (64),
    .LINE_WIDTH     (512),
    .ID_WIDTH       (4)
  ) dut (
    .clk          (clk),
    .arstn        (arstn),
    .i_start_read (i_start_read),
    .i_addr       (i_addr),
    .o_line       (o_line),
    .o_read_last  (o_read_last),
    .o_busy       (o_busy),
    .o_error      (o_error),
    .o_arid       (o_arid),
    .o_araddr     (o_araddr),
    .o_arlen      (o_arlen),
    .o_arsize     (o_arsize),
    .o_arburst    (o_arburst),
    .o_arvalid    (o_arvalid),
    .i_arready    (i_arready),
    .i_rid        (i_rid),
    .i_rdata      (i_rdata),
    .i_rresp      (i_rresp),
    .i_rlast      (i_rlast),
    .i_rvalid     (i_rvalid),
    .o_rready     (o_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count completion pulses and AR handshakes independently of the burst tasks.
  always @(negedge clk) begin
    if (o_read_last) n_last++;
    if (o_arvalid && i_arready) n_ar++;
  end

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_arvalid"},   o_arvalid,   0);
    check_eq({tag, "_rready"},    o_rready,    0);
    check_eq({tag, "_read_last"}, o_read_last, 0);
    check_eq({tag, "_busy"},      o_busy,      0);
    check_eq({tag, "_error"},     o_error,     0);
    check_eq({tag, "_line"},      o_line,      0);
    check_eq({tag, "_araddr"},    o_araddr,    0);
    check_eq({tag, "_arlen"},     o_arlen,     0);
    check_eq({tag, "_arsize"},    o_arsize,    0);
    check_eq({tag, "_arburst"},   o_arburst,   0);
    check_eq({tag, "_arid"},      o_arid,      0);
  endtask

  // bad_kind: 0 none, 1 SLVERR on bad_beat, 2 nonzero RID on bad_beat,
  //           3 early RLAST on bad_beat (<7), 4 RLAST missing on beat 7
  // gap_mode: 0 back-to-back, 1 RVALID every other cycle, 2 random gaps
  task automatic do_burst(input logic [63:0] addr, input int ar_wait, input int gap_mode,
                          input int bad_kind, input int bad_beat, input bit seq_data,
                          input bit busy_start);
    logic [63:0]  data [8];
    logic [511:0] exp_line;
    logic [63:0]  exp_araddr;
    logic         exp_err;
    logic         gap;
    logic         gap_toggle;
    logic [1:0]   resp;
    logic [3:0]   rid;
    logic         rlast;
    int           cyc;
    int           b;
    int           guard;
    int           last0;
    int           ar0;

    exp_araddr = addr - (addr % 64);
    exp_err    = 1'b0;
    gap_toggle = 1'b0;
    for (int k = 0; k < 8; k++) begin
      data[k] = seq_data ? 64'(k) : {$urandom, $urandom};
      exp_line[k*64 +: 64] = data[k];
    end
    last0 = n_last;
    ar0   = n_ar;

    i_start_read = 1'b1;
    i_addr       = addr;
    @(posedge clk); #1;
    cyc          = 1;
    i_start_read = 1'b0;
    i_addr       = {$urandom, $urandom};
    check_eq("ar_valid",   o_arvalid, 1);
    check_eq("ar_addr",    o_araddr,  exp_araddr);
    check_eq("ar_len",     o_arlen,   7);
    check_eq("ar_size",    o_arsize,  3);
    check_eq("ar_burst",   o_arburst, 1);
    check_eq("ar_id",      o_arid,    0);
    check_eq("busy_start", o_busy,    1);
    check_eq("err_clear",  o_error,   0);

    repeat (ar_wait) begin
      @(posedge clk); #1;
      cyc++;
      check_eq("ar_hold_valid", o_arvalid, 1);
      check_eq("ar_hold_addr",  o_araddr,  exp_araddr);
      check_eq("ar_hold_len",   o_arlen,   7);
    end
    i_arready = 1'b1;
    @(posedge clk); #1;
    cyc++;
    i_arready = 1'b0;
    check_eq("ar_dropped", o_arvalid, 0);

    b     = 0;
    guard = 0;
    while (b < 8 && guard < 400) begin
      guard++;
      case (gap_mode)
        1:       begin gap_toggle = ~gap_toggle; gap = gap_toggle; end
        2:       gap = ($urandom_range(0, 2) == 0);
        default: gap = 1'b0;
      endcase
      check_eq("rready", o_rready, 1);
      if (busy_start && b == 2) begin
        i_start_read = 1'b1;
        i_addr       = addr ^ 64'h1000;
      end
      if (gap) begin
        i_rvalid = 1'b0;
        i_rdata  = {$urandom, $urandom};
        i_rlast  = 1'($urandom);
        @(posedge clk); #1;
        cyc++;
        i_start_read = 1'b0;
        check_eq("gap_no_last", o_read_last, 0);
      end else begin
        resp  = (bad_kind == 1 && b == bad_beat) ? 2'b10 : 2'b00;
        rid   = (bad_kind == 2 && b == bad_beat) ? 4'($urandom_range(1, 15)) : 4'd0;
        rlast = (b == 7);
        if (bad_kind == 3 && b == bad_beat) rlast = 1'b1;
        if (bad_kind == 4 && b == 7)        rlast = 1'b0;
        i_rvalid = 1'b1;
        i_rdata  = data[b];
        i_rresp  = resp;
        i_rid    = rid;
        i_rlast  = rlast;
        @(posedge clk); #1;
        cyc++;
        i_rvalid     = 1'b0;
        i_start_read = 1'b0;
        i_rresp      = 2'b00;
        i_rid        = 4'd0;
        i_rlast      = 1'b0;
        if (resp != 2'b00 || rid != 4'd0 || rlast != (b == 7)) exp_err = 1'b1;
        b++;
        check_eq("beat_error", o_error, exp_err);
        if (b < 8) check_eq("no_early_done", o_read_last, 0);
      end
    end
    if (b < 8) check_eq("beat_timeout", b, 8);

    check_eq("done_pulse", o_read_last, 1);
    check_eq("done_line",  o_line,      exp_line);
    check_eq("done_error", o_error,     exp_err);
    check_eq("done_busy",  o_busy,      1);
    check_eq("done_addr",  o_araddr,    exp_araddr);
    if (ar_wait == 0 && gap_mode == 0) check_eq("latency", cyc, 10);

    @(posedge clk); #1;
    check_eq("pulse_end",  o_read_last, 0);
    check_eq("idle_busy",  o_busy,      0);
    check_eq("idle_arv",   o_arvalid,   0);
    check_eq("line_hold",  o_line,      exp_line);
    check_eq("one_pulse",  n_last - last0, 1);
    check_eq("one_ar",     n_ar - ar0,     1);
  endtask

  task automatic reset_mid_burst();
    i_start_read = 1'b1;
    i_addr       = 64'hdead_beef_0000_1f40;
    i_arready    = 1'b1;
    @(posedge clk); #1;
    i_start_read = 1'b0;
    @(posedge clk); #1;
    i_arready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_rvalid = 1'b1;
      i_rdata  = {$urandom, $urandom};
      i_rresp  = (k == 1) ? 2'b11 : 2'b00;
      i_rlast  = 1'b0;
      @(posedge clk); #1;
    end
    check_eq("pre_reset_error", o_error, 1);
    check_eq("pre_reset_rready", o_rready, 1);
    #2;
    arstn    = 1'b0;
    i_rvalid = 1'b0;
    i_rresp  = 2'b00;
    #1;
    check_all_zero("async_rst");
    @(posedge clk); #1;
    check_all_zero("held_rst");
    arstn = 1'b1;
    @(posedge clk); #1;
    check_eq("post_rst_idle", o_busy, 0);
  endtask

  initial begin
    arstn        = 1'b0;
    i_start_read = 1'b0;
    i_addr       = '0;
    i_arready    = 1'b0;
    i_rid        = '0;
    i_rdata      = '0;
    i_rresp      = '0;
    i_rlast      = 1'b0;
    i_rvalid     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    arstn = 1'b1;
    @(posedge clk); #1;

    do_burst(64'h1234, 0, 0, 0, 0, 1'b1, 1'b0);
    do_burst({$urandom, $urandom}, 5, 1, 0, 0, 1'b0, 1'b0);
    do_burst({$urandom, $urandom}, 0, 0, 1, 3, 1'b0, 1'b0);
    do_burst({$urandom, $urandom}, 1, 0, 0, 0, 1'b0, 1'b0);
    do_burst({$urandom, $urandom}, 0, 0, 3, 5, 1'b0, 1'b0);
    do_burst({$urandom, $urandom}, 0, 0, 4, 7, 1'b0, 1'b0);
    do_burst({$urandom, $urandom}, 0, 1, 2, 6, 1'b0, 1'b0);
    do_burst(64'h0000_0000_0004_0080, 0, 0, 0, 0, 1'b0, 1'b1);

    reset_mid_burst();
    do_burst(64'h1234, 0, 0, 0, 0, 1'b1, 1'b0);

    for (int t = 0; t < 24; t++) begin
      int kind;
      int bad;
      kind = $urandom_range(0, 4);
      bad  = (kind == 3) ? $urandom_range(0, 6) : $urandom_range(0, 7);
      do_burst({$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 2),
               kind, bad, 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_line_fetch.md
# axi_line_fetch

AXI4 read initiator that refills the instruction cache. On a start request from the control unit, it issues one INCR burst for the 64-byte line that contains the requested address. It assembles the returned 64-bit beats into a 512-bit line. It then delivers the line together with a one-cycle `o_read_last` pulse, which drives the core's `i_read_last` and `i_instr_axi` inputs.

## Interface
Parameters:
- `ADDR_WIDTH`, 64: AXI and core address width.
- `AXI_DATA_WIDTH`, 64: R channel data width.
- `LINE_WIDTH`, 512: cache line width. `BEATS = LINE_WIDTH/AXI_DATA_WIDTH` = 8.
- `ID_WIDTH`, 4: AXI ID width. The block uses a fixed `ARID` of 0.

Ports:
- Clock and reset:
  - `clk`, input, 1: single clock for the whole block.
  - `arstn`, input, 1: asynchronous reset, active-low.
- Core side:
  - `i_start_read`, input, 1: refill request, from the control unit's `o_start_read`.
  - `i_addr`, input, ADDR_WIDTH: miss address (byte address).
  - `o_line`, output, LINE_WIDTH: assembled line. Beat k occupies bits [64k+63:64k].
  - `o_read_last`, output, 1: one-cycle pulse meaning the line is complete.
  - `o_busy`, output, 1: high in every state except IDLE.
  - `o_error`, output, 1: sticky error for the last burst. Cleared on the next accepted start.
- AXI AR channel:
  - `o_arid`, output, ID_WIDTH
  - `o_araddr`, output, ADDR_WIDTH
  - `o_arlen`, output, 8
  - `o_arsize`, output, 3
  - `o_arburst`, output, 2
  - `o_arvalid`, output, 1
  - `i_arready`, input, 1
- AXI R channel:
  - `i_rid`, input, ID_WIDTH
  - `i_rdata`, input, AXI_DATA_WIDTH
  - `i_rresp`, input, 2
  - `i_rlast`, input, 1
  - `i_rvalid`, input, 1
  - `o_rready`, output, 1

## Operation
- The FSM has four states: IDLE, ADDR, DATA, DONE.
- IDLE:
  - On `i_start_read`=1, latch `{i_addr[ADDR_WIDTH-1:6], 6'b0}`, clear `o_error`, reset the beat counter to 0, and go to ADDR.
- ADDR:
  - Drive `o_arvalid`=1 with `arlen`=BEATS-1 (7), `arsize`=3, `arburst`=2'b01 (INCR), `arid`=0.
  - All AR signals are held stable until `i_arready`=1, then go to DATA.
- DATA:
  - Drive `o_rready`=1.
  - On each `i_rvalid`=1, write `i_rdata` into slot `beat_cnt` and increment `beat_cnt`.
  - Set `o_error` on any of:
    - `i_rresp`≠2'b00
    - `i_rid`≠0
    - `i_rlast`=1 while `beat_cnt`≠7
    - `i_rlast`=0 while `beat_cnt`=7
  - On the beat with `beat_cnt`=7, go to DONE regardless of `i_rlast`. The protocol violation is flagged but does not hang the block.
- DONE:
  - Assert `o_read_last` for exactly one cycle, then go to IDLE.
- `i_start_read` is ignored while `o_busy`=1. A start that is still held high in the IDLE cycle after DONE begins a new burst.
- `o_line` holds its value from DONE until the first beat of the next burst overwrites slot 0. The cache samples it in the `o_read_last` cycle.
- `beat_cnt` is 3 bits and wraps from 7 to 0 only on the transition to DONE.

## Timing
- Reset values:
  - state = IDLE
  - `o_arvalid`, `o_rready`, `o_read_last`, `o_busy`, `o_error` = 0
  - `o_line` = 0
  - `o_araddr` = 0, `o_arlen` = 0, `o_arsize` = 0, `o_arburst` = 0, `o_arid` = 0
- All outputs are registered or decoded from the state register. There is no combinational path from `i_arready` or `i_rvalid` to any output.
- Minimum latency, with `i_arready` and `i_rvalid` held at 1 (start sampled at edge T):
  - `o_arvalid` high during cycle T+1; AR handshake at T+1.
  - Beats accepted in cycles T+2 to T+9.
  - `o_read_last` high during cycle T+10.
  - `o_busy` falls at T+11.
- Backpressure:
  - `i_arready` low keeps the FSM in ADDR indefinitely.
  - `i_rvalid` gaps stall DATA with no timeout.
- Reset asserted mid-burst: the FSM returns to IDLE immediately and all outputs take their reset values. Outstanding AXI beats are the interconnect's concern, and the bench must reset both sides together.

## Structure
- Shared package `axi_pkg` holds:
  - `AXI_BURST_INCR`
  - `AXI_RESP_OKAY`
  - `AXI_SIZE_8B`
  - the typedef `fetch_state_t` enum {IDLE, ADDR, DATA, DONE}
- One sub-module, `line_buffer`: an 8-slot 64-bit register array with write enable and slot index, and a flat 512-bit output. The FSM, counter and AR registers stay in `axi_line_fetch`.

## Test plan
- Reset check: assert `arstn`=0 mid-DATA, then release. Required: all outputs 0, FSM in IDLE, and a new start works normally.
- Nominal refill: start with `i_addr`=0x1234 and `i_arready`=`i_rvalid`=1; beats carry data 0x0..0x7 with `rlast` on beat 7. Required:
  - `araddr`=0x1200, `arlen`=7, `arsize`=3, `arburst`=1
  - `o_read_last` pulse at T+10
  - `o_line[63:0]`=0, `o_line[511:448]`=7
  - `o_error`=0
- Backpressure: `i_arready` low for 5 cycles, and `i_rvalid` toggling every other cycle. Required: AR fields stable while waiting, the line is assembled correctly, and exactly one `o_read_last` pulse.
- Error response: beat 3 returns `rresp`=2'b10. Required: `o_error`=1 after beat 3, the burst still completes with a `o_read_last` pulse, and `o_error` clears on the next start.
- `rlast` violation: `rlast` asserted early on beat 5, with beats 6–7 still supplied. Required: `o_error`=1, and the FSM reaches DONE only after beat 7.
- Start while busy: pulse `i_start_read` with a different address during DATA. Required: ignored, so no second AR is issued and `araddr` is unchanged.
